// File: rtl/hp_pkg.sv
// Package hp_pkg: shared binary16 constants, operand classification and
// flag bit positions for the half-precision arithmetic blocks (hp_mul, hp_div_seq).
// Contents:
//   EXP_W / FRAC_W / EXP_BIAS : binary16 field layout
//   QNAN / PINF               : canonical quiet NaN and positive infinity
//   FLAG_*                    : bit positions inside the 4-bit flags vector
//   hp_class_e + classify()   : operand class, subnormals read as zero (DAZ)
//   div_state_e               : divider FSM states
package hp_pkg;

  localparam int unsigned EXP_W    = 5;
  localparam int unsigned FRAC_W   = 10;
  localparam int unsigned EXP_BIAS = 15;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;

  // flags = {invalid, div_by_zero, overflow, underflow}
  localparam int unsigned FLAG_UNDERFLOW   = 0;
  localparam int unsigned FLAG_OVERFLOW    = 1;
  localparam int unsigned FLAG_DIV_BY_ZERO = 2;
  localparam int unsigned FLAG_INVALID     = 3;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } hp_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Classify the magnitude bits {exp, frac}; a zero exponent field is zero
  // regardless of the fraction, so subnormal inputs behave as zero.
  function automatic hp_class_e classify(input logic [14:0] mag);
    hp_class_e cls;
    if (mag[14:10] == 5'd0) begin
      cls = ZERO;
    end else if (mag[14:10] == 5'h1F) begin
      cls = (mag[9:0] != 10'd0) ? NAN : INF;
    end else begin
      cls = NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/hp_round_pack.sv
// hp_round_pack: combinational normalise / round / pack stage for binary16.
// Takes a 14-bit quotient-style significand in [2^12, 2^14), the remainder
// left by the division (only its non-zero-ness matters), a signed biased
// exponent and the result sign, and produces the packed binary16 result.
// Results that leave the normal range flush to zero or saturate to infinity.
// Ports:
//   quot      in  14  significand, leading one at bit 13 or bit 12
//   rem       in  12  remainder, contributes to sticky
//   exponent  in  7   signed biased exponent for a bit-13-aligned significand
//   sign      in  1   result sign
//   q         out 16  packed result
//   overflow  out 1   exponent reached 31 or more after rounding
//   underflow out 1   exponent reached 0 or less after rounding (flush to zero)
module hp_round_pack
  import hp_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic [13:0] quot,
  input  logic [11:0] rem,
  input  logic [6:0]  exponent,
  input  logic        sign,
  output logic [15:0] q,
  output logic        overflow,
  output logic        underflow
);

  logic [9:0]        frac_s;
  logic [9:0]        frac_rnd_s;
  logic              guard_s;
  logic              sticky_s;
  logic              inc_s;
  logic              carry_s;
  logic signed [7:0] exp_norm_s;
  logic signed [7:0] exp_rnd_s;

  // Normalise so the hidden one is dropped and guard/sticky are split out.
  always_comb begin
    frac_s     = 10'd0;
    guard_s    = 1'b0;
    sticky_s   = 1'b0;
    exp_norm_s = $signed({exponent[6], exponent});
    if (quot[13]) begin
      frac_s   = quot[12:3];
      guard_s  = quot[2];
      sticky_s = (|quot[1:0]) | (|rem);
    end else begin
      frac_s     = quot[11:2];
      guard_s    = quot[1];
      sticky_s   = quot[0] | (|rem);
      exp_norm_s = $signed({exponent[6], exponent}) - 8'sd1;
    end
  end

  // Round to nearest even; an all-ones fraction carries into the exponent
  // and the 10-bit fraction wraps to zero, which is exactly 1.0 x 2^(e+1).
  always_comb begin
    inc_s = 1'b0;
    if (ROUND_NEAREST) begin
      inc_s = guard_s & (sticky_s | frac_s[0]);
    end else begin
      inc_s = 1'b0;
    end
    frac_rnd_s = frac_s + {9'd0, inc_s};
    carry_s    = inc_s & (&frac_s);
    exp_rnd_s  = exp_norm_s + $signed({7'd0, carry_s});
  end

  // Pack with saturation to infinity and flush to zero.
  always_comb begin
    q         = 16'h0000;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (exp_rnd_s >= 8'sd31) begin
      q        = {sign, PINF[14:0]};
      overflow = 1'b1;
    end else if (exp_rnd_s <= 8'sd0) begin
      q         = {sign, 15'h0000};
      underflow = 1'b1;
    end else begin
      q = {sign, exp_rnd_s[4:0], frac_rnd_s};
    end
  end

endmodule

// File: rtl/hp_div_seq.sv
// hp_div_seq: iterative binary16 divider q = a / b.
// Restoring radix-2 division of the 11-bit significands, one quotient bit per
// clock (14 bits), then one normalise/round cycle. Special operands bypass
// the iteration and finish in one cycle. One operation in flight.
// Ports:
//   clk        in   1   clock
//   rst        in   1   synchronous active-high reset, aborts any operation
//   in_valid   in   1   a/b valid
//   in_ready   out  1   accepting a/b (idle and not in reset)
//   a, b       in   16  dividend / divisor, binary16
//   out_valid  out  1   q/flags valid, held until out_ready
//   out_ready  in   1   consumer accepts result
//   q          out  16  quotient, binary16
//   flags      out  4   {invalid, div_by_zero, overflow, underflow}
module hp_div_seq
  import hp_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q,
  output logic [3:0]  flags
);

  div_state_e  state_r;
  logic [3:0]  cnt_r;
  logic [13:0] quot_r;
  logic [11:0] rem_r;
  logic [10:0] mb_r;
  logic [6:0]  exp_r;
  logic        sign_r;

  hp_class_e   cls_a_s;
  hp_class_e   cls_b_s;
  logic        sign_s;
  logic [6:0]  exp_s;
  logic        spec_hit_s;
  logic [15:0] spec_q_s;
  logic [3:0]  spec_flags_s;

  logic [11:0] diff_s;
  logic        qbit_s;
  logic [10:0] rsub_s;

  logic [15:0] rp_q_s;
  logic        rp_ovf_s;
  logic        rp_unf_s;

  assign in_ready = (state_r == ST_IDLE) && !rst;

  // Classify operands and resolve special cases in priority order.
  always_comb begin
    cls_a_s      = classify(a[14:0]);
    cls_b_s      = classify(b[14:0]);
    sign_s       = a[15] ^ b[15];
    exp_s        = {2'b00, a[14:10]} - {2'b00, b[14:10]} + 7'(EXP_BIAS);
    spec_hit_s   = 1'b1;
    spec_q_s     = 16'h0000;
    spec_flags_s = 4'b0000;
    if ((cls_a_s == NAN) || (cls_b_s == NAN)) begin
      spec_q_s = QNAN;
    end else if (((cls_a_s == ZERO) && (cls_b_s == ZERO)) ||
                 ((cls_a_s == INF) && (cls_b_s == INF))) begin
      spec_q_s                   = QNAN;
      spec_flags_s[FLAG_INVALID] = 1'b1;
    end else if (cls_b_s == ZERO) begin
      // a is finite nonzero (divide by zero) or infinite (inf / finite)
      spec_q_s                       = {sign_s, PINF[14:0]};
      spec_flags_s[FLAG_DIV_BY_ZERO] = (cls_a_s == NORM);
    end else if (cls_a_s == INF) begin
      spec_q_s = {sign_s, PINF[14:0]};
    end else if ((cls_b_s == INF) || (cls_a_s == ZERO)) begin
      spec_q_s = {sign_s, 15'h0000};
    end else begin
      spec_hit_s = 1'b0;
    end
  end

  // One restoring step: partial remainder stays below 2*mb, so a 12-bit
  // signed difference is enough and its sign gives the quotient bit.
  always_comb begin
    diff_s = rem_r - {1'b0, mb_r};
    qbit_s = ~diff_s[11];
    if (qbit_s) begin
      rsub_s = diff_s[10:0];
    end else begin
      rsub_s = rem_r[10:0];
    end
  end

  hp_round_pack #(
    .ROUND_NEAREST (ROUND_NEAREST)
  ) u_round_pack (
    .quot      (quot_r),
    .rem       (rem_r),
    .exponent  (exp_r),
    .sign      (sign_r),
    .q         (rp_q_s),
    .overflow  (rp_ovf_s),
    .underflow (rp_unf_s)
  );

  // Control FSM, iteration datapath and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      out_valid <= 1'b0;
      q         <= 16'h0000;
      flags     <= 4'b0000;
      cnt_r     <= 4'd0;
      quot_r    <= 14'd0;
      rem_r     <= 12'd0;
      mb_r      <= 11'd0;
      exp_r     <= 7'd0;
      sign_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            sign_r <= sign_s;
            if (spec_hit_s) begin
              q         <= spec_q_s;
              flags     <= spec_flags_s;
              out_valid <= 1'b1;
              state_r   <= ST_DONE;
            end else begin
              rem_r   <= {1'b0, 1'b1, a[9:0]};
              mb_r    <= {1'b1, b[9:0]};
              exp_r   <= exp_s;
              quot_r  <= 14'd0;
              cnt_r   <= 4'd0;
              state_r <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          quot_r <= {quot_r[12:0], qbit_s};
          rem_r  <= {rsub_s, 1'b0};
          cnt_r  <= cnt_r + 4'd1;
          if (cnt_r == 4'd13) begin
            state_r <= ST_NORM;
          end
        end
        ST_NORM: begin
          q         <= rp_q_s;
          flags     <= {2'b00, rp_ovf_s, rp_unf_s};
          out_valid <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hp_div_seq.sv
// Self-checking bench for hp_div_seq. Two instances run in lockstep: one with
// round-to-nearest-even, one truncating. Directed vectors carry hand-derived
// expectations; random vectors use an arithmetic reference model.
module tb_hp_div_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] q;
  logic [3:0]  flags;
  logic        in_ready_t;
  logic        out_valid_t;
  logic [15:0] q_t;
  logic [3:0]  flags_t;

  int n_total;
  int n_bad;

  hp_div_seq #(.ROUND_NEAREST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .flags(flags)
  );

  hp_div_seq #(.ROUND_NEAREST(1'b0)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .a(a), .b(b), .out_valid(out_valid_t), .out_ready(out_ready),
    .q(q_t), .flags(flags_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference: returns {special, flags[3:0], q[15:0]} from plain arithmetic.
  function automatic logic [20:0] ref_div(input logic [15:0] x, input logic [15:0] y, input bit rn);
    logic s;
    int ea, eb, ma, mb, num, mant, r, e;
    bit xz, yz, xi, yi, xn, yn;
    s  = x[15] ^ y[15];
    ea = int'(x[14:10]);
    eb = int'(y[14:10]);
    xz = (ea == 0);
    yz = (eb == 0);
    xi = (ea == 31) && (x[9:0] == 10'd0);
    yi = (eb == 31) && (y[9:0] == 10'd0);
    xn = (ea == 31) && (x[9:0] != 10'd0);
    yn = (eb == 31) && (y[9:0] != 10'd0);
    if (xn || yn) return {1'b1, 4'b0000, 16'h7E00};
    if ((xz && yz) || (xi && yi)) return {1'b1, 4'b1000, 16'h7E00};
    if (yz) return xi ? {1'b1, 4'b0000, s, 15'h7C00} : {1'b1, 4'b0100, s, 15'h7C00};
    if (xi) return {1'b1, 4'b0000, s, 15'h7C00};
    if (yi || xz) return {1'b1, 4'b0000, s, 15'h0000};
    ma  = 1024 + int'(x[9:0]);
    mb  = 1024 + int'(y[9:0]);
    e   = ea - eb + 15;
    num = ma;
    if (ma < mb) begin
      num = 2 * ma;
      e   = e - 1;
    end
    mant = (num * 1024) / mb;
    r    = (num * 1024) % mb;
    if (rn && ((2 * r > mb) || ((2 * r == mb) && (mant % 2 == 1)))) mant++;
    if (mant == 2048) begin
      mant = 1024;
      e++;
    end
    if (e >= 31) return {1'b0, 4'b0010, s, 15'h7C00};
    if (e <= 0) return {1'b0, 4'b0001, s, 15'h0000};
    return {1'b0, 4'b0000, s, 5'(e), 10'(mant)};
  endfunction

  // One transaction: accept, measure latency, check result, optional
  // backpressure, then handshake and check return to idle.
  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb,
                        input logic [15:0] eq, input logic [3:0] ef,
                        input int elat, input int hold);
    logic [20:0] mt;
    int n;
    int busy_bad;
    int stable_bad;
    mt = ref_div(xa, xb, 1'b0);
    @(negedge clk);
    chk("idle_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = xa;
    b = xb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~xa;
    b = ~xb;
    n = 0;
    busy_bad = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      if (in_ready) busy_bad++;
    end
    chk("latency", 32'(n), 32'(elat));
    chk("busy_rdy", 32'(busy_bad), 32'd0);
    chk("q", 32'(q), 32'(eq));
    chk("flags", 32'(flags), 32'(ef));
    chk("trunc_ov", 32'(out_valid_t), 32'd1);
    chk("trunc_q", 32'(q_t), 32'(mt[15:0]));
    chk("trunc_flags", 32'(flags_t), 32'(mt[19:16]));
    if (hold > 0) begin
      stable_bad = 0;
      for (int k = 0; k < hold; k++) begin
        in_valid = 1'b1;
        a = 16'($urandom);
        b = 16'($urandom);
        @(negedge clk);
        if (!out_valid || (q != eq) || (flags != ef) || in_ready) stable_bad++;
      end
      in_valid = 1'b0;
      chk("hold_stable", 32'(stable_bad), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_rdy", 32'(in_ready), 32'd1);
    chk("post_ov", 32'(out_valid), 32'd0);
    chk("post_rdy_t", 32'(in_ready_t), 32'd1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [3:0]  f;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [20:0] m;
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    out_ready = 1'b0;

    vecs[0]  = '{16'h4200, 16'h4000, 16'h3E00, 4'b0000, 16, 0};
    vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, 4'b0000, 16, 0};
    vecs[2]  = '{16'h8400, 16'h4000, 16'h8000, 4'b0001, 16, 0};
    vecs[3]  = '{16'h3C00, 16'h0000, 16'h7C00, 4'b0100, 1, 0};
    vecs[4]  = '{16'h0000, 16'h0000, 16'h7E00, 4'b1000, 1, 0};
    vecs[5]  = '{16'h7C00, 16'h7C00, 16'h7E00, 4'b1000, 1, 0};
    vecs[6]  = '{16'h7E00, 16'h3C00, 16'h7E00, 4'b0000, 1, 0};
    vecs[7]  = '{16'hBC00, 16'h7C00, 16'h8000, 4'b0000, 1, 0};
    vecs[8]  = '{16'h7BFF, 16'h1400, 16'h7C00, 4'b0010, 16, 0};
    vecs[9]  = '{16'h0400, 16'h4000, 16'h0000, 4'b0001, 16, 0};
    vecs[10] = '{16'h0200, 16'h3C00, 16'h0000, 4'b0000, 1, 0};
    vecs[11] = '{16'h3BFF, 16'h3BFE, 16'h3C01, 4'b0000, 16, 0};
    vecs[12] = '{16'h4200, 16'h4000, 16'h3E00, 4'b0000, 16, 5};
    vecs[13] = '{16'h3C00, 16'h0000, 16'h7C00, 4'b0100, 1, 5};
    vecs[14] = '{16'h7C00, 16'h0000, 16'h7C00, 4'b0000, 1, 0};
    vecs[15] = '{16'hFC00, 16'h3C00, 16'hFC00, 4'b0000, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_rdy", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].f, vecs[i].lat, vecs[i].hold);
    end

    // Abort in the fifth division cycle.
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h4200;
    b = 16'h4000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ov", 32'(out_valid), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    chk("abort_rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_release_rdy", 32'(in_ready), 32'd1);
    run_op(16'h4200, 16'h4000, 16'h3E00, 4'b0000, 16, 0);

    // Random operands, mostly in the normal range.
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ((i % 4) != 0) begin
        ra[14:10] = 5'($urandom_range(30, 1));
        rb[14:10] = 5'($urandom_range(30, 1));
      end
      m = ref_div(ra, rb, 1'b1);
      run_op(ra, rb, m[15:0], m[19:16], m[20] ? 1 : 16, (i % 7 == 3) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
